// File: rtl/piano_pkg.sv
// Shared constants, types and helpers for the piano voice scheduler.
package piano_pkg;
  localparam int NUM_VOICES = 4;
  localparam int ADDR_W     = 11;
  localparam int AGE_W      = 8;
  localparam int NOTE_BITS  = 3;
  localparam int NUM_NOTES  = 1 << NOTE_BITS;
  localparam int VIDX_W     = $clog2(NUM_VOICES);
  localparam logic [15:0] END_MARKER = 16'hFFFF;

  typedef logic [NOTE_BITS-1:0] note_t;

  typedef struct packed {
    logic  valid;
    note_t note;
  } key_dec_t;

  typedef struct packed {
    logic             active;
    note_t            note;
    logic [ADDR_W-1:0] addr;
    logic [AGE_W-1:0]  age;
  } voice_t;

  // USB keycode byte to note index; unknown codes come back not valid
  function automatic key_dec_t key_decode(input logic [7:0] b);
    key_dec_t d;
    d.valid = 1'b1;
    d.note  = '0;
    case (b)
      8'h04: d.note = 3'd0;
      8'h16: d.note = 3'd1;
      8'h07: d.note = 3'd2;
      8'h09: d.note = 3'd3;
      8'h0B: d.note = 3'd4;
      8'h0D: d.note = 3'd5;
      8'h0E: d.note = 3'd6;
      8'h0F: d.note = 3'd7;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

  // each note owns a 256-word region of the sample RAM
  function automatic logic [ADDR_W-1:0] note_base(input note_t n);
    return {n, 8'h00};
  endfunction
endpackage

// File: rtl/keycode_to_note.sv
// Combinational keycode byte decoder.
module keycode_to_note
  import piano_pkg::*;
(
  input  logic [7:0] key_byte,
  output key_dec_t   dec
);
  // pure table lookup
  always_comb dec = key_decode(key_byte);
endmodule

// File: rtl/piano_voice_scheduler.sv
// Per-frame keycode scan, voice allocation and sample address advance.
module piano_voice_scheduler
  import piano_pkg::*;
(
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic                                sample_tick,
  input  logic [31:0]                         keycode,
  input  logic [NUM_VOICES-1:0][15:0]         sample_data,
  output logic [NUM_VOICES-1:0][ADDR_W-1:0]   read_address,
  output logic [NUM_VOICES-1:0]               voice_active,
  output logic [NUM_VOICES-1:0][NOTE_BITS-1:0] voice_note,
  output logic                                frame_done,
  output logic                                overrun
);
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ALLOC, S_ADV} state_t;

  state_t state, state_nx;
  logic [1:0]            cnt;
  logic [31:0]           kc_q;
  logic [NUM_NOTES-1:0]  held, done_mask, owned, pend;
  voice_t [NUM_VOICES-1:0] vs;
  logic [NUM_VOICES-1:0] asg;
  note_t [NUM_VOICES-1:0] asg_note;

  logic [1:0]            slot;
  key_dec_t              dec;
  logic                  pend_vld, free_vld, steal_vld;
  note_t                 pend_note;
  logic [VIDX_W-1:0]     free_v, steal_v;
  logic [AGE_W-1:0]      steal_age;

  // slot 0 lives in the top byte
  assign slot = 2'd3 - cnt;
  keycode_to_note u_dec (.key_byte(kc_q[{slot, 3'b000} +: 8]), .dec(dec));

  // state and in-state cycle counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? 2'd0 : cnt + 2'd1;
    end
  end

  // next state; frame_done marks the ADVANCE cycle
  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    case (state)
      S_IDLE:  if (sample_tick) state_nx = S_SCAN;
      S_SCAN:  if (cnt == 2'd3) state_nx = S_ALLOC;
      S_ALLOC: if (cnt == 2'd3) state_nx = S_ADV;
      S_ADV: begin
        state_nx   = S_IDLE;
        frame_done = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // pick the next new note, a free voice, and a steal victim
  always_comb begin
    owned     = '0;
    pend_vld  = 1'b0;
    pend_note = '0;
    free_vld  = 1'b0;
    free_v    = '0;
    steal_vld = 1'b0;
    steal_v   = '0;
    steal_age = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      if (vs[v].active) owned[vs[v].note] = 1'b1;
    pend = held & ~owned & ~done_mask;
    for (int n = NUM_NOTES-1; n >= 0; n--)
      if (pend[n]) begin
        pend_vld  = 1'b1;
        pend_note = note_t'(n);
      end
    // a voice whose key is released this frame is as good as free
    for (int v = NUM_VOICES-1; v >= 0; v--)
      if (!asg[v] && (!vs[v].active || !held[vs[v].note])) begin
        free_vld = 1'b1;
        free_v   = VIDX_W'(v);
      end
    // never steal a voice handed out earlier in this same frame
    for (int v = 0; v < NUM_VOICES; v++)
      if (!asg[v] && vs[v].active && (!steal_vld || vs[v].age > steal_age)) begin
        steal_vld = 1'b1;
        steal_v   = VIDX_W'(v);
        steal_age = vs[v].age;
      end
  end

  // frame scratch: latched keycode, held mask, pending assignments
  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_q      <= '0;
      held      <= '0;
      done_mask <= '0;
      asg       <= '0;
      asg_note  <= '0;
    end else begin
      case (state)
        S_IDLE: if (sample_tick) begin
          kc_q      <= keycode;
          held      <= '0;
          done_mask <= '0;
          asg       <= '0;
        end
        S_SCAN: if (dec.valid) held[dec.note] <= 1'b1;
        S_ALLOC: if (pend_vld) begin
          done_mask[pend_note] <= 1'b1;
          if (free_vld) begin
            asg[free_v]      <= 1'b1;
            asg_note[free_v] <= pend_note;
          end else if (steal_vld) begin
            asg[steal_v]      <= 1'b1;
            asg_note[steal_v] <= pend_note;
          end
        end
        default: ;
      endcase
    end
  end

  // voice state only moves in ADVANCE
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs <= '0;
    end else if (state == S_ADV) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (asg[v]) begin
          vs[v].active <= 1'b1;
          vs[v].note   <= asg_note[v];
          vs[v].addr   <= note_base(asg_note[v]);
          vs[v].age    <= '0;
        end else if (vs[v].active) begin
          if (!held[vs[v].note]) begin
            vs[v].active <= 1'b0;
          end else begin
            if (sample_data[v] == END_MARKER)
              vs[v].addr <= note_base(vs[v].note);
            else
              vs[v].addr <= {vs[v].addr[ADDR_W-1:8], vs[v].addr[7:0] + 8'd1};
            if (vs[v].age != '1) vs[v].age <= vs[v].age + AGE_W'(1);
          end
        end
      end
    end
  end

  // sticky flag for a tick that lands mid-frame
  always_ff @(posedge Clk) begin
    if (Reset) overrun <= 1'b0;
    else if (sample_tick && state != S_IDLE) overrun <= 1'b1;
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
    assign read_address[v] = vs[v].addr;
    assign voice_active[v] = vs[v].active;
    assign voice_note[v]   = vs[v].note;
  end
endmodule
